// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three-source round-robin common-data-bus arbiter with per-source queues
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              alu_broadcast,
    input  logic [DATA_W-1:0] alu_cbd_value,
    input  logic [TAG_W-1:0]  alu_update_rename,
    output logic              alu_cdb_ready,
    input  logic              lsb_broadcast,
    input  logic [DATA_W-1:0] lsb_cbd_value,
    input  logic [TAG_W-1:0]  lsb_update_rename,
    output logic              lsb_cdb_ready,
    input  logic              rob_broadcast,
    input  logic [DATA_W-1:0] rob_cbd_value,
    input  logic [TAG_W-1:0]  rob_update_rename,
    output logic              rob_cdb_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_value,
    output logic [TAG_W-1:0]  cdb_rename,
    output logic [1:0]        cdb_src,
    output logic              overflow_err
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [2:0]        push, ready, accept, cand, enq, pop;
    logic [DATA_W-1:0] in_val [3];
    logic [TAG_W-1:0]  in_tag [3];
    logic [DATA_W-1:0] mem_val [3][QDEPTH];
    logic [TAG_W-1:0]  mem_tag [3][QDEPTH];
    logic [PW-1:0]     wr_ptr [3];
    logic [PW-1:0]     rd_ptr [3];
    logic [CW-1:0]     cnt [3];
    logic [1:0]        rr_last, gsel, idx;
    logic              found, grant;
    logic [DATA_W-1:0] sel_val;
    logic [TAG_W-1:0]  sel_tag;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign push   = {rob_broadcast, lsb_broadcast, alu_broadcast};
    assign in_val = '{alu_cbd_value, lsb_cbd_value, rob_cbd_value};
    assign in_tag = '{alu_update_rename, lsb_update_rename, rob_update_rename};
    assign alu_cdb_ready = ready[0];
    assign lsb_cdb_ready = ready[1];
    assign rob_cdb_ready = ready[2];

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            ready[s]  = rdy & ~jump_wrong & (cnt[s] < CW'(QDEPTH));
            accept[s] = push[s] & ready[s];
            cand[s]   = (cnt[s] != '0) | accept[s];
        end
    end

    always_comb begin
        found = 1'b0;
        gsel  = 2'd0;
        idx   = nxt(rr_last);
        for (int k = 0; k < 3; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
            idx = nxt(idx);
        end
        grant = rdy & ~jump_wrong & found;
    end

    // A granted source pops its head if it has one, otherwise its push bypasses the queue.
    always_comb begin
        sel_val = '0;
        sel_tag = '0;
        for (int s = 0; s < 3; s++) begin
            pop[s] = grant & (gsel == 2'(s)) & (cnt[s] != '0);
            enq[s] = accept[s] & ~(grant & (gsel == 2'(s)) & (cnt[s] == '0));
            if (gsel == 2'(s)) begin
                sel_val = (cnt[s] != '0) ? mem_val[s][rd_ptr[s]] : in_val[s];
                sel_tag = (cnt[s] != '0) ? mem_tag[s][rd_ptr[s]] : in_tag[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (enq[s]) begin
                mem_val[s][wr_ptr[s]] <= in_val[s];
                mem_tag[s][wr_ptr[s]] <= in_tag[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 3; s++) begin
                cnt[s]    <= '0;
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
            end
            rr_last      <= 2'd2;
            cdb_valid    <= 1'b0;
            cdb_value    <= '0;
            cdb_rename   <= '0;
            cdb_src      <= 2'd0;
            overflow_err <= 1'b0;
        end else begin
            if (|(push & ~ready)) overflow_err <= 1'b1;
            if (jump_wrong) begin
                for (int s = 0; s < 3; s++) begin
                    cnt[s]    <= '0;
                    wr_ptr[s] <= '0;
                    rd_ptr[s] <= '0;
                end
                rr_last   <= 2'd2;
                cdb_valid <= 1'b0;
            end else if (!rdy) begin
                cdb_valid <= 1'b0;
            end else begin
                for (int s = 0; s < 3; s++) begin
                    wr_ptr[s] <= wr_ptr[s] + PW'(enq[s]);
                    rd_ptr[s] <= rd_ptr[s] + PW'(pop[s]);
                    cnt[s]    <= cnt[s] + CW'(enq[s]) - CW'(pop[s]);
                end
                cdb_valid <= grant;
                if (grant) begin
                    rr_last    <= gsel;
                    cdb_value  <= sel_val;
                    cdb_rename <= sel_tag;
                    cdb_src    <= gsel;
                end
            end
        end
    end
endmodule
